// File: rtl/mmio_periph_bridge_pkg.sv
// Shared definitions for the MMIO peripheral bridge: I/O window base, register offsets,
// decoded-select enum and the address decoder. MMIO_TIMER_EN enables the TIMER register.
package mmio_pkg;

  localparam logic [31:0] IO_BASE           = 32'hFFFF0000;
  localparam logic [7:0]  OFF_SW            = 8'h04;
  localparam logic [7:0]  OFF_SEG           = 8'h0C;
  localparam logic [7:0]  OFF_LED           = 8'h10;
  localparam logic [7:0]  OFF_TIMER         = 8'h14;
  localparam logic [31:0] SEG_RESET_DEFAULT = 32'hAA5555AA;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_SW,
    SEL_SEG,
    SEL_LED,
    SEL_TIMER
  } reg_sel_e;

  // Word-granular decode: the byte lane bits addr[1:0] never take part.
  function automatic reg_sel_e decode(input logic [31:0] a);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (a[31:8] != IO_BASE[31:8]) begin
      sel = SEL_RAM;
    end else begin
      case ({a[7:2], 2'b00})
        OFF_SW:    sel = SEL_SW;
        OFF_SEG:   sel = SEL_SEG;
        OFF_LED:   sel = SEL_LED;
`ifdef MMIO_TIMER_EN
        OFF_TIMER: sel = SEL_TIMER;
`endif
        default:   sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/mmio_periph_bridge_if.sv
// CPU data-port bundle between the core (master) and the MMIO bridge (slave),
// including the RAM read data that the bridge muxes back to the core.
interface mmio_periph_bridge_if;
  logic        cpu_ce;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] dm_rdata;
  logic        dm_we;

  modport master (
    output cpu_ce, mem_w, addr, wdata, dm_rdata,
    input  rdata, dm_we
  );

  modport slave (
    input  cpu_ce, mem_w, addr, wdata, dm_rdata,
    output rdata, dm_we
  );
endinterface

// File: rtl/mmio_periph_bridge_sw_filter.sv
// One switch bit: two-flop synchronizer followed by a stability-counter debouncer.
// A new level is accepted after DB_CYCLES consecutive stable synchronized cycles.
module sw_filter #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rstn_i,
  input  logic sw_i,
  output logic sw_db
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer into one stage.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      if (sync2_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
        db_q  <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign sw_db = db_q;

endmodule

// File: rtl/mmio_periph_bridge.sv
// MMIO bridge on the CPU data port: decodes the I/O window, owns SW/SEG/LED (and TIMER
// when MMIO_TIMER_EN is defined) registers, muxes load data and gates RAM writes.
module mmio_periph_bridge
  import mmio_pkg::*;
#(
  parameter int          DB_CYCLES = 1000000,
  parameter int          TICK_DIV  = 100000,
  parameter logic [31:0] SEG_RESET = SEG_RESET_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rstn_i,
  mmio_periph_bridge_if.slave  bus,
  input  logic [15:0]          sw_i,
  output logic [31:0]          seg_value,
  output logic [15:0]          led_o
);

  reg_sel_e    sel;
  logic        wr;
  logic [15:0] sw_db;
  logic [31:0] seg_q;
  logic [15:0] led_q;

  assign sel = decode(bus.addr);
  assign wr  = bus.cpu_ce & bus.mem_w;

  for (genvar i = 0; i < 16; i++) begin : g_sw
    sw_filter #(.DB_CYCLES(DB_CYCLES)) u_sw_filter (
      .clk    (clk),
      .rstn_i (rstn_i),
      .sw_i   (sw_i[i]),
      .sw_db  (sw_db[i])
    );
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      seg_q <= SEG_RESET;
      led_q <= '0;
    end else if (wr) begin
      if (sel == SEL_SEG) seg_q <= bus.wdata;
      if (sel == SEL_LED) led_q <= bus.wdata[15:0];
    end
  end

`ifdef MMIO_TIMER_EN
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc_q;
  logic [31:0]   timer_q;
  logic          tick;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  // A CPU write restarts the millisecond phase and swallows a coincident tick.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      presc_q <= '0;
      timer_q <= '0;
    end else if (wr && sel == SEL_TIMER) begin
      presc_q <= '0;
      timer_q <= bus.wdata;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) timer_q <= timer_q + 32'd1;
    end
  end
`endif

  // NOTE: every output of a combinational block gets a default first; a path that
  // leaves it unassigned would infer a latch.
  always_comb begin
    bus.rdata = '0;
    case (sel)
      SEL_RAM:   bus.rdata = bus.dm_rdata;
      SEL_SW:    bus.rdata = {16'b0, sw_db};
      SEL_SEG:   bus.rdata = seg_q;
      SEL_LED:   bus.rdata = {16'b0, led_q};
`ifdef MMIO_TIMER_EN
      SEL_TIMER: bus.rdata = timer_q;
`endif
      default:   bus.rdata = '0;
    endcase
  end

  assign bus.dm_we  = wr & (sel == SEL_RAM);
  assign seg_value  = seg_q;
  assign led_o      = led_q;

endmodule

// File: tb/tb_mmio_periph_bridge.sv
// Directed bench for mmio_periph_bridge with DB_CYCLES=4, TICK_DIV=3: register/bus
// vectors from a table, plus hand-written switch, timer and reset sequences.
module tb_mmio_periph_bridge;

  logic        clk;
  logic        rstn_i;
  logic [15:0] sw_i;
  logic [31:0] seg_value;
  logic [15:0] led_o;

  int tests;
  int fails;

  mmio_periph_bridge_if bus ();

  mmio_periph_bridge #(
    .DB_CYCLES (4),
    .TICK_DIV  (3)
  ) dut (
    .clk       (clk),
    .rstn_i    (rstn_i),
    .bus       (bus.slave),
    .sw_i      (sw_i),
    .seg_value (seg_value),
    .led_o     (led_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dm;
    logic [31:0] exp_rdata;
    logic        exp_dm_we;
    logic [31:0] exp_seg;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tmr(input logic [31:0] v);
`ifdef MMIO_TIMER_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  task automatic drive(input logic ce, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] dm);
    bus.cpu_ce   = ce;
    bus.mem_w    = we;
    bus.addr     = a;
    bus.wdata    = wd;
    bus.dm_rdata = dm;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rstn_i = 1'b0;
    sw_i   = 16'h0;
    drive(1'b0, 1'b0, 32'hFFFF0004, 32'h0, 32'h0);

    vecs[0]  = '{"rd_seg_rst",  1'b0, 1'b0, 32'hFFFF000C, 32'h0,        32'h0,        32'hAA5555AA, 1'b0, 32'hAA5555AA, 16'h0000};
    vecs[1]  = '{"rd_led_rst",  1'b0, 1'b0, 32'hFFFF0010, 32'h0,        32'h0,        32'h00000000, 1'b0, 32'hAA5555AA, 16'h0000};
    vecs[2]  = '{"rd_sw_rst",   1'b0, 1'b0, 32'hFFFF0004, 32'h0,        32'h0,        32'h00000000, 1'b0, 32'hAA5555AA, 16'h0000};
    vecs[3]  = '{"st_seg",      1'b1, 1'b1, 32'hFFFF000C, 32'h12345678, 32'h0,        32'hAA5555AA, 1'b0, 32'h12345678, 16'h0000};
    vecs[4]  = '{"st_seg_noce", 1'b0, 1'b1, 32'hFFFF000C, 32'hDEADBEEF, 32'h0,        32'h12345678, 1'b0, 32'h12345678, 16'h0000};
    vecs[5]  = '{"ram_store",   1'b1, 1'b1, 32'h00000040, 32'h55555555, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 32'h12345678, 16'h0000};
    vecs[6]  = '{"ram_noce",    1'b0, 1'b1, 32'h00000040, 32'h55555555, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 32'h12345678, 16'h0000};
    vecs[7]  = '{"st_hole",     1'b1, 1'b1, 32'hFFFF0020, 32'h11111111, 32'h99999999, 32'h00000000, 1'b0, 32'h12345678, 16'h0000};
    vecs[8]  = '{"st_led",      1'b1, 1'b1, 32'hFFFF0010, 32'hABCD5A5A, 32'h0,        32'h00000000, 1'b0, 32'h12345678, 16'h5A5A};
    vecs[9]  = '{"rd_led_b3",   1'b0, 1'b0, 32'hFFFF0013, 32'h0,        32'h0,        32'h00005A5A, 1'b0, 32'h12345678, 16'h5A5A};
    vecs[10] = '{"rd_seg_b2",   1'b0, 1'b0, 32'hFFFF000E, 32'h0,        32'h0,        32'h12345678, 1'b0, 32'h12345678, 16'h5A5A};
    vecs[11] = '{"st_sw_ro",    1'b1, 1'b1, 32'hFFFF0004, 32'h0000FFFF, 32'h77777777, 32'h00000000, 1'b0, 32'h12345678, 16'h5A5A};
    vecs[12] = '{"ram_ff01",    1'b1, 1'b1, 32'hFFFF0100, 32'h0,        32'h13572468, 32'h13572468, 1'b1, 32'h12345678, 16'h5A5A};

    // Reset state while rstn_i is held low.
    repeat (2) @(negedge clk);
    #1;
    check("rst_seg", seg_value, 32'hAA5555AA);
    check("rst_led", {16'h0, led_o}, 32'h0);
    check("rst_sw", bus.rdata, 32'h0);
    bus.addr = 32'hFFFF0014;
    #1;
    check("rst_timer", bus.rdata, 32'h0);
    @(negedge clk);
    rstn_i = 1'b1;

    // Bus/register vectors: combinational outputs before the edge, registers after.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].ce, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].dm);
      #1;
      check({vecs[i].name, "_rdata"}, bus.rdata, vecs[i].exp_rdata);
      check({vecs[i].name, "_dm_we"}, {31'h0, bus.dm_we}, {31'h0, vecs[i].exp_dm_we});
      @(posedge clk);
      #1;
      bus.cpu_ce = 1'b0;
      bus.mem_w  = 1'b0;
      check({vecs[i].name, "_seg"}, seg_value, vecs[i].exp_seg);
      check({vecs[i].name, "_led"}, {16'h0, led_o}, {16'h0, vecs[i].exp_led});
    end

    // Switch debounce: stable level appears exactly 2 + DB_CYCLES edges later.
    @(negedge clk);
    drive(1'b0, 1'b0, 32'hFFFF0004, 32'h0, 32'h0);
    sw_i = 16'h8001;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) check("sw_early", bus.rdata, 32'h00000000);
      if (k == 6) check("sw_settled", bus.rdata, 32'h00008001);
    end

    // A 3-cycle glitch on bit 2 must be filtered out.
    @(negedge clk);
    sw_i = 16'h8005;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sw_i = 16'h8001;
    repeat (10) @(posedge clk);
    #1;
    check("sw_glitch", bus.rdata, 32'h00008001);

    // Asynchronous reset mid-operation clears everything without a clock edge.
    @(negedge clk);
    bus.addr = 32'hFFFF0014;
    #2;
    rstn_i = 1'b0;
    #1;
    check("arst_timer", bus.rdata, 32'h0);
    check("arst_seg", seg_value, 32'hAA5555AA);
    check("arst_led", {16'h0, led_o}, 32'h0);
    bus.addr = 32'hFFFF0004;
    #1;
    check("arst_sw", bus.rdata, 32'h0);
    bus.addr = 32'hFFFF0014;
    @(negedge clk);
    rstn_i = 1'b1;

    // Timer free-run: 9 edges after release at TICK_DIV=3 gives 3.
    repeat (9) @(posedge clk);
    #1;
    check("tmr_free9", bus.rdata, tmr(32'h3));

    // Write on the cycle the prescaler would tick: the write wins.
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(1'b1, 1'b1, 32'hFFFF0014, 32'hFFFFFFFF, 32'h24682468);
    #1;
    check("tmr_wr_dm_we", {31'h0, bus.dm_we}, 32'h0);
    @(posedge clk);
    #1;
    bus.cpu_ce = 1'b0;
    bus.mem_w  = 1'b0;
    check("tmr_loaded", bus.rdata, tmr(32'hFFFFFFFF));
    repeat (2) @(posedge clk);
    #1;
    check("tmr_hold", bus.rdata, tmr(32'hFFFFFFFF));
    @(posedge clk);
    #1;
    check("tmr_wrap", bus.rdata, tmr(32'h0));
    repeat (3) @(posedge clk);
    #1;
    check("tmr_after_wrap", bus.rdata, tmr(32'h1));

    // Reset mid-count clears TIMER immediately.
    #2;
    rstn_i = 1'b0;
    #1;
    check("tmr_arst", bus.rdata, 32'h0);
    @(negedge clk);
    rstn_i = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
